vga_pattern_gen: RTL

- Parametrised, synthesisable VGA timing generator with a built-in multi-mode test-pattern source.
- Generalises the fixed 640x480@60 Hz, 8-bit RRR GGG BB flow: resolution, porch/sync widths, sync polarity and per-channel colour depth are parameters; several selectable patterns are added.
- Sits in front of the VGA output pins or feeds the log-based VGA simulator. It gives bring-up patterns without a frame source.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing.sv | 111 +++++++++++
 rtl/vga_pattern_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 default timing, pattern mode encodings
// and a helper that sums the regions of one axis into its total period.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam logic [2:0] MODE_SOLID = 3'd0;
   localparam logic [2:0] MODE_BARS  = 3'd1;
   localparam logic [2:0] MODE_CHECK = 3'd2;
   localparam logic [2:0] MODE_GRAD  = 3'd3;
   localparam logic [2:0] MODE_ALT   = 3'd4;

   function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                         input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line/frame counters plus registered sync, blanking,
// frame-start and position outputs, all one cycle behind the counters.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned H_FP        = DEF_H_FP,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BP        = DEF_H_BP,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned V_FP        = DEF_V_FP,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BP        = DEF_V_BP,
   parameter bit          SYNC_ACTIVE = 1'b0,
   localparam int unsigned H_TOTAL    = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int unsigned V_TOTAL    = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int unsigned HW         = $clog2(H_TOTAL),
   localparam int unsigned VW         = $clog2(V_TOTAL)
) (
   input  logic          pixel_clk,
   input  logic          reset,
   input  logic          enable,
   output logic [HW-1:0] hc,
   output logic [VW-1:0] vc,
   output logic          active,
   output logic          first_pixel,
   output logic          frame_odd,
   output logic          h_sync,
   output logic          v_sync,
   output logic          display_on,
   output logic          frame_start,
   output logic [15:0]   frame_count,
   output logic [HW-1:0] pix_x,
   output logic [VW-1:0] pix_y
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] hc_q, hc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic [15:0]   fc_q, fc_d;
   logic          hs_win, vs_win;

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      fc_d = fc_q;
      if (enable) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d = '0;
               fc_d = fc_q + 16'd1;
            end else begin
               vc_d = vc_q + 1'b1;
            end
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign active      = (hc_q < H_ACT) && (vc_q < V_ACT);
   assign first_pixel = (hc_q == '0) && (vc_q == '0);
   assign frame_odd   = fc_q[0];
   assign hs_win      = (hc_q >= H_SS) && (hc_q < H_SE);
   assign vs_win      = (vc_q >= V_SS) && (vc_q < V_SE);

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         hc_q <= '0;
         vc_q <= '0;
         fc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
         fc_q <= fc_d;
      end
   end

   // Outputs describe the pixel the counters pointed at before this edge.
   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         h_sync      <= ~SYNC_ACTIVE;
         v_sync      <= ~SYNC_ACTIVE;
         display_on  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
      end else begin
         h_sync      <= (enable && hs_win) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         v_sync      <= (enable && vs_win) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         display_on  <= enable && active;
         frame_start <= enable && first_pixel;
         frame_count <= fc_q;
         pix_x       <= hc_q;
         pix_y       <= vc_q;
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with a selectable test-pattern source; mode and colour
// are latched at frame start so a frame is always drawn with one setting.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned H_FP        = DEF_H_FP,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BP        = DEF_H_BP,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned V_FP        = DEF_V_FP,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BP        = DEF_V_BP,
   parameter bit          SYNC_ACTIVE = 1'b0,
   parameter int unsigned R_W         = 3,
   parameter int unsigned G_W         = 3,
   parameter int unsigned B_W         = 2,
   parameter int unsigned CHECK_SHIFT = 5,
   localparam int unsigned HW         = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   localparam int unsigned VW         = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP)),
   localparam int unsigned CW         = R_W + G_W + B_W
) (
   input  logic          pixel_clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [2:0]    mode,
   input  logic [CW-1:0] solid_color,
   output logic          h_sync,
   output logic          v_sync,
   output logic [CW-1:0] rgb,
   output logic          display_on,
   output logic          frame_start,
   output logic [15:0]   frame_count,
   output logic [HW-1:0] pix_x,
   output logic [VW-1:0] pix_y
);

   if (H_ACTIVE < 8) begin : g_bad_h_active
      $fatal(1, "vga_pattern_gen: H_ACTIVE must be at least 8");
   end
   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
   begin : g_bad_porch
      $fatal(1, "vga_pattern_gen: porch and sync widths must be non-zero");
   end
   if (R_W == 0 || G_W == 0 || B_W == 0) begin : g_bad_colour
      $fatal(1, "vga_pattern_gen: colour channel widths must be non-zero");
   end

   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
   localparam int unsigned   G_TOP = $clog2(H_ACTIVE);
   // Gradient takes the top W bits below G_TOP; pad with zeros if W exceeds G_TOP.
   localparam int unsigned   R_SR  = (G_TOP >= R_W) ? G_TOP - R_W : 0;
   localparam int unsigned   R_SL  = (G_TOP <  R_W) ? R_W - G_TOP : 0;
   localparam int unsigned   G_SR  = (G_TOP >= G_W) ? G_TOP - G_W : 0;
   localparam int unsigned   G_SL  = (G_TOP <  G_W) ? G_W - G_TOP : 0;
   localparam int unsigned   B_SR  = (G_TOP >= B_W) ? G_TOP - B_W : 0;
   localparam int unsigned   B_SL  = (G_TOP <  B_W) ? B_W - G_TOP : 0;

   logic [HW-1:0] hc;
   logic [VW-1:0] vc;
   logic          active, first_pixel, frame_odd;
   logic [2:0]    mode_s, mode_eff;
   logic [CW-1:0] color_s, color_eff;
   logic [HW-1:0] bar_idx;
   logic [2:0]    bar;
   logic          check_on;
   logic [R_W-1:0] grad_r;
   logic [G_W-1:0] grad_g;
   logic [B_W-1:0] grad_b;
   logic [CW-1:0] pattern, rgb_d;

   vga_timing #(
      .H_ACTIVE    (H_ACTIVE),
      .H_FP        (H_FP),
      .H_SYNC      (H_SYNC),
      .H_BP        (H_BP),
      .V_ACTIVE    (V_ACTIVE),
      .V_FP        (V_FP),
      .V_SYNC      (V_SYNC),
      .V_BP        (V_BP),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_timing (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .enable      (enable),
      .hc          (hc),
      .vc          (vc),
      .active      (active),
      .first_pixel (first_pixel),
      .frame_odd   (frame_odd),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .display_on  (display_on),
      .frame_start (frame_start),
      .frame_count (frame_count),
      .pix_x       (pix_x),
      .pix_y       (pix_y)
   );

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         mode_s  <= MODE_SOLID;
         color_s <= '0;
      end else if (enable && first_pixel) begin
         mode_s  <= mode;
         color_s <= solid_color;
      end
   end

   // Pixel (0,0) is drawn in the same cycle the shadows load, so bypass them there.
   assign mode_eff  = first_pixel ? mode : mode_s;
   assign color_eff = first_pixel ? solid_color : color_s;

   always_comb begin
      bar_idx  = hc / BAR_W;
      bar      = (bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0];
      check_on = (((32'(hc) ^ 32'(vc)) >> CHECK_SHIFT) & 32'd1) != 32'd0;
      grad_r   = R_W'((32'(hc) >> R_SR) << R_SL);
      grad_g   = G_W'((32'(hc) >> G_SR) << G_SL);
      grad_b   = B_W'((32'(hc) >> B_SR) << B_SL);
   end

   always_comb begin
      pattern = '0;
      case (mode_eff)
         MODE_SOLID: pattern = color_eff;
         MODE_BARS:  pattern = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
         MODE_CHECK: pattern = {CW{check_on}};
         MODE_GRAD:  pattern = {grad_r, grad_g, grad_b};
         MODE_ALT:   pattern = frame_odd ? ~color_eff : color_eff;
         default:    pattern = '0;
      endcase
      rgb_d = (enable && active) ? pattern : '0;
   end

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         rgb <= '0;
      end else begin
         rgb <= rgb_d;
      end
   end

endmodule
